// File: rtl/rs_sched_pkg.sv
// Shared definitions for the RS latch scheduler: FSM state encoding and command opcodes.
package rs_sched_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t PULSE  = 2'd1;
  localparam state_t SETTLE = 2'd2;
  localparam state_t CHECK  = 2'd3;

  localparam logic OP_SET   = 1'b1;
  localparam logic OP_RESET = 1'b0;

endpackage

// File: rtl/rs_latch_scheduler_if.sv
// Requester handshakes, latch-bank lines and status for the RS latch scheduler.
interface rs_latch_scheduler_if #(
  parameter int N_LATCH = 4,
  parameter int IDX_W   = 2
);
  logic               a_valid;
  logic               a_op;
  logic [IDX_W-1:0]   a_idx;
  logic               a_ready;
  logic               b_valid;
  logic               b_op;
  logic [IDX_W-1:0]   b_idx;
  logic               b_ready;
  logic [N_LATCH-1:0] s;
  logic [N_LATCH-1:0] r;
  logic [N_LATCH-1:0] q;
  logic               busy;
  logic               done;
  logic               grant_b;
  logic               err;

  modport master (
    output a_valid, a_op, a_idx, b_valid, b_op, b_idx, q,
    input  a_ready, b_ready, s, r, busy, done, grant_b, err
  );

  modport slave (
    input  a_valid, a_op, a_idx, b_valid, b_op, b_idx, q,
    output a_ready, b_ready, s, r, busy, done, grant_b, err
  );
endinterface

// File: rtl/rs_latch_scheduler_arb.sv
// Two-way round-robin arbiter: on a collision the pointer side wins, otherwise the lone requester.
module rr_arb2 (
  input  logic a_valid,
  input  logic b_valid,
  input  logic ptr_b,
  output logic gnt_a,
  output logic gnt_b
);
  always_comb begin
    gnt_a = a_valid & (~b_valid | ~ptr_b);
    gnt_b = b_valid & (~a_valid | ptr_b);
  end
endmodule

// File: rtl/rs_latch_scheduler.sv
// Sequences A/B set/reset commands onto an RS latch bank as registered, mutually exclusive pulses.
// Define RS_READBACK_CHECK_EN to add the CHECK state that compares q[idx] against the command.
module rs_latch_scheduler
  import rs_sched_pkg::*;
#(
  parameter int N_LATCH   = 4,
  parameter int PULSE_CYC = 2,
  parameter int IDX_W     = 2
) (
  input  logic                clk,
  input  logic                rst,
  rs_latch_scheduler_if.slave bus
);

`ifdef RS_READBACK_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  localparam int CNT_W = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               op_reg, op_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic               bad_reg, bad_next;
  logic               gb_reg, gb_next;
  logic               ptr_reg, ptr_next;
  logic [N_LATCH-1:0] s_reg, s_next, r_reg, r_next;
  logic [N_LATCH-1:0] hit_next, hit_reg;
  logic               gnt_a, gnt_b, in_op, q_sel;
  logic [IDX_W-1:0]   in_idx;

  rr_arb2 u_arb (
    .a_valid (bus.a_valid),
    .b_valid (bus.b_valid),
    .ptr_b   (ptr_reg),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b)
  );

  assign in_op  = gnt_b ? bus.b_op  : bus.a_op;
  assign in_idx = gnt_b ? bus.b_idx : bus.a_idx;

  generate
    for (genvar gi = 0; gi < N_LATCH; gi++) begin : g_lane
      assign hit_next[gi] = (idx_next == IDX_W'(gi));
      assign hit_reg[gi]  = (idx_reg  == IDX_W'(gi));
    end
  endgenerate

  assign q_sel = |(bus.q & hit_reg);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Command context is captured on accept and held until the FSM returns to IDLE.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    idx_next   = idx_reg;
    bad_next   = bad_reg;
    gb_next    = gb_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (gnt_a | gnt_b) begin
          op_next    = in_op;
          idx_next   = in_idx;
          gb_next    = gnt_b;
          bad_next   = (32'(in_idx) >= 32'(N_LATCH));
          cnt_next   = '0;
          ptr_next   = (bus.a_valid & bus.b_valid) ? ~ptr_reg : ptr_reg;
          state_next = (32'(in_idx) >= 32'(N_LATCH)) ? SETTLE : PULSE;
        end
      end
      PULSE: begin
        if (cnt_reg == CNT_W'(PULSE_CYC - 1)) state_next = SETTLE;
        else                                  cnt_next   = cnt_reg + 1'b1;
      end
      SETTLE:  state_next = (CHECK_EN && !bad_reg) ? CHECK : IDLE;
      CHECK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // s/r are computed from the upcoming state so the bank sees clean registered pulses.
  always_comb begin
    s_next = '0;
    r_next = '0;
    if (state_next == PULSE) begin
      s_next = op_next ? hit_next : '0;
      r_next = op_next ? '0 : hit_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      op_reg  <= OP_RESET;
      idx_reg <= '0;
      bad_reg <= 1'b0;
      gb_reg  <= 1'b0;
      ptr_reg <= 1'b0;
      s_reg   <= '0;
      r_reg   <= '0;
    end else begin
      cnt_reg <= cnt_next;
      op_reg  <= op_next;
      idx_reg <= idx_next;
      bad_reg <= bad_next;
      gb_reg  <= gb_next;
      ptr_reg <= ptr_next;
      s_reg   <= s_next;
      r_reg   <= r_next;
    end
  end

  always_comb begin
    bus.a_ready = (state_reg == IDLE) & ~rst & gnt_a;
    bus.b_ready = (state_reg == IDLE) & ~rst & gnt_b;
    bus.busy    = (state_reg != IDLE);
    bus.done    = ((state_reg == SETTLE) && (bad_reg || !CHECK_EN)) || (state_reg == CHECK);
    bus.err     = ((state_reg == SETTLE) && bad_reg) || ((state_reg == CHECK) && (q_sel != op_reg));
    bus.grant_b = gb_reg;
    bus.s       = s_reg;
    bus.r       = r_reg;
  end

endmodule

// File: tb/tb_rs_latch_scheduler.sv
// Randomized self-checking bench for rs_latch_scheduler with a latch-bank model and stuck-bit injection.
module tb_rs_latch_scheduler;
  localparam int P = 2;
`ifdef RS_READBACK_CHECK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rs_latch_scheduler_if #(.N_LATCH(4), .IDX_W(2)) bus ();
  rs_latch_scheduler_if #(.N_LATCH(3), .IDX_W(2)) bus3 ();

  rs_latch_scheduler #(.N_LATCH(4), .PULSE_CYC(P), .IDX_W(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  rs_latch_scheduler #(.N_LATCH(3), .PULSE_CYC(P), .IDX_W(2)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Latch bank: set/reset behaviour plus forced stuck bits.
  logic [3:0] bank   = 4'b0;
  logic [3:0] stuck1 = 4'b0;
  logic [3:0] stuck0 = 4'b0;
  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (bus.s[i]) bank[i] <= 1'b1;
      else if (bus.r[i]) bank[i] <= 1'b0;
  assign bus.q  = (bank & ~stuck0) | stuck1;
  assign bus3.q = 3'b0;

  always @(negedge clk) begin
    n_tests++;
    assert (((bus.s & bus.r) == 4'b0) && ($countones(bus.s | bus.r) <= 1) &&
            ((bus3.s & bus3.r) == 3'b0) && ($countones(bus3.s | bus3.r) <= 1))
    else begin
      n_fail++;
      $display("FAIL invariant s=%b r=%b s3=%b r3=%b required disjoint with at most one bit", bus.s, bus.r, bus3.s, bus3.r);
    end
  end

  // Requester model
  bit         a_pend = 0, b_pend = 0, ptr_b = 0;
  bit         a_op_v, b_op_v;
  logic [1:0] a_idx_v, b_idx_v;

  task automatic set_a(input bit op, input logic [1:0] idx);
    a_op_v = op; a_idx_v = idx; a_pend = 1;
    bus.a_op = op; bus.a_idx = idx; bus.a_valid = 1'b1;
  endtask

  task automatic set_b(input bit op, input logic [1:0] idx);
    b_op_v = op; b_idx_v = idx; b_pend = 1;
    bus.b_op = op; bus.b_idx = idx; bus.b_valid = 1'b1;
  endtask

  // Called just after a rising edge with the DUT idle; returns just after a rising edge.
  task automatic serve_one(input string tag);
    int         waited, lat;
    bit         win_b, op, exp_q, exp_err;
    logic [1:0] idx;
    logic [3:0] oh, exp_s, exp_r;
    waited = 0;
    @(negedge clk);
    while (!(bus.a_ready || bus.b_ready) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    win_b = (a_pend && b_pend) ? ptr_b : b_pend;
    n_tests++;
    if (bus.a_ready !== !win_b || bus.b_ready !== win_b || waited != 0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s accept: a_ready=%b b_ready=%b busy=%b done=%b wait=%0d, required a_ready=%b b_ready=%b busy=0 done=0 wait=0",
               tag, bus.a_ready, bus.b_ready, bus.busy, bus.done, waited, !win_b, win_b);
    end
    if (waited >= 20) begin
      @(posedge clk); #1;
      bus.a_valid = 1'b0; bus.b_valid = 1'b0; a_pend = 0; b_pend = 0;
      return;
    end
    if (a_pend && b_pend) ptr_b = !ptr_b;
    op      = win_b ? b_op_v : a_op_v;
    idx     = win_b ? b_idx_v : a_idx_v;
    oh      = 4'b0;
    oh[idx] = 1'b1;
    exp_q   = stuck1[idx] ? 1'b1 : (stuck0[idx] ? 1'b0 : op);
    exp_err = (CHK != 0) && (exp_q != op);
    lat     = P + 1 + CHK;
    @(posedge clk); #1;
    if (win_b) begin bus.b_valid = 1'b0; b_pend = 0; end
    else       begin bus.a_valid = 1'b0; a_pend = 0; end
    for (int t = 1; t <= lat; t++) begin
      @(negedge clk);
      exp_s = (t <= P && op)  ? oh : 4'b0;
      exp_r = (t <= P && !op) ? oh : 4'b0;
      n_tests++;
      if (bus.s !== exp_s || bus.r !== exp_r || bus.done !== (t == lat) || bus.err !== (t == lat && exp_err) ||
          bus.busy !== 1'b1 || bus.grant_b !== win_b || bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s t=%0d: s=%b r=%b done=%b err=%b busy=%b grant_b=%b rdy=%b%b, required s=%b r=%b done=%b err=%b busy=1 grant_b=%b rdy=00",
                 tag, t, bus.s, bus.r, bus.done, bus.err, bus.busy, bus.grant_b, bus.a_ready, bus.b_ready,
                 exp_s, exp_r, (t == lat), (t == lat && exp_err), win_b);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.a_valid = 1'b1; bus.a_op = 1'b1; bus.a_idx = 2'd0;
    bus.b_valid = 1'b0; bus.b_op = 1'b0; bus.b_idx = 2'd0;
    bus3.a_valid = 1'b0; bus3.a_op = 1'b0; bus3.a_idx = 2'd0;
    bus3.b_valid = 1'b0; bus3.b_op = 1'b0; bus3.b_idx = 2'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({bus.s, bus.r, bus.busy, bus.done, bus.err, bus.grant_b, bus.a_ready, bus.b_ready} !== 14'b0) begin
      n_fail++;
      $display("FAIL reset: s=%b r=%b busy=%b done=%b err=%b grant_b=%b rdy=%b%b, required all zero",
               bus.s, bus.r, bus.busy, bus.done, bus.err, bus.grant_b, bus.a_ready, bus.b_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0; bus.a_valid = 1'b0; ptr_b = 0;
  endtask

  task automatic test_collision();
    set_a(1'b1, 2'd0); set_b(1'b0, 2'd3);
    serve_one("coll1_a");
    serve_one("coll1_b");
    set_a(1'b0, 2'd0); set_b(1'b1, 2'd3);
    serve_one("coll2_b");
    serve_one("coll2_a");
  endtask

  task automatic test_basic_set();
    set_a(rs_sched_pkg::OP_SET, 2'd2);
    serve_one("set_idx2");
  endtask

  task automatic test_readback_mismatch();
    stuck1 = 4'b0010;
    set_a(rs_sched_pkg::OP_RESET, 2'd1);
    serve_one("mismatch_idx1");
    stuck1 = 4'b0;
  endtask

  task automatic test_out_of_range();
    bus3.a_valid = 1'b1; bus3.a_op = 1'b1; bus3.a_idx = 2'd3;
    @(negedge clk);
    n_tests++;
    if (bus3.a_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL oob accept: a_ready=%b required 1", bus3.a_ready);
    end
    @(posedge clk); #1;
    bus3.a_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({bus3.s, bus3.r, bus3.done, bus3.err, bus3.busy} !== 9'b000_000_111) begin
      n_fail++;
      $display("FAIL oob accept+1: s=%b r=%b done=%b err=%b busy=%b, required s=000 r=000 done=1 err=1 busy=1",
               bus3.s, bus3.r, bus3.done, bus3.err, bus3.busy);
    end
    @(negedge clk);
    n_tests++;
    if ({bus3.s, bus3.r, bus3.done, bus3.err, bus3.busy} !== 9'b0) begin
      n_fail++;
      $display("FAIL oob accept+2: s=%b r=%b done=%b err=%b busy=%b, required all zero",
               bus3.s, bus3.r, bus3.done, bus3.err, bus3.busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_pulse();
    set_a(1'b1, 2'd3);
    @(negedge clk);
    n_tests++;
    if (bus.a_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst accept: a_ready=%b required 1", bus.a_ready);
    end
    @(posedge clk); #1;
    bus.a_valid = 1'b0; a_pend = 0;
    @(negedge clk);
    n_tests++;
    if (bus.s !== 4'b1000 || bus.r !== 4'b0) begin
      n_fail++;
      $display("FAIL midrst pulse1: s=%b r=%b, required s=1000 r=0000", bus.s, bus.r);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (bus.s !== 4'b0 || bus.r !== 4'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.a_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst after edge: s=%b r=%b busy=%b done=%b a_ready=%b, required all zero",
               bus.s, bus.r, bus.busy, bus.done, bus.a_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0; ptr_b = 0;
    set_a(1'b0, 2'd3);
    serve_one("midrst_recover");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int pat;
      pat    = int'($urandom_range(0, 2));
      stuck1 = 4'b0;
      stuck0 = 4'b0;
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1) stuck1[$urandom_range(0, 3)] = 1'b1;
        else                           stuck0[$urandom_range(0, 3)] = 1'b1;
      end
      if (pat != 1) set_a(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      if (pat != 0) set_b(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      serve_one("rand");
      if (pat == 2) serve_one("rand_second");
    end
    stuck1 = 4'b0;
    stuck0 = 4'b0;
  endtask

  initial begin
    test_reset();
    test_collision();
    test_basic_set();
    test_readback_mismatch();
    test_out_of_range();
    test_reset_mid_pulse();
    test_random();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
